// File: rtl/dm_cache_wt_if.sv
// Request/response bundle for the direct-mapped write-through cache.
// The requester drives the master side and the cache sits on the slave side.
interface dm_cache_wt_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_hit;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_hit
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_hit
  );

endinterface

// File: rtl/dm_cache_wt.sv
// Direct-mapped, write-through cache with an embedded backing RAM model.
// Accepts one request at a time over a valid/ready port and answers with a
// single-cycle response pulse. The backing RAM has RAM_LAT cycles of latency.
// Optional feature macro: WRITE_ALLOCATE_EN (write misses install the line).
// Without it the cache is write-no-allocate.
module dm_cache_wt #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4,
  parameter int RAM_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  dm_cache_wt_if.slave  bus
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 2 ** INDEX_W;
  localparam int WORDS = 2 ** ADDR_W;
  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

`ifdef WRITE_ALLOCATE_EN
  localparam bit WriteAlloc = 1'b1;
`else
  localparam bit WriteAlloc = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MEM,
    RESP
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  // Latched copy of the accepted request
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;

  // Cache arrays: only the valid bits are reset
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_arr  [LINES];
  logic [DATA_W-1:0]  data_arr [LINES];

  // Backing RAM, zero at time 0 and never reset
  logic [DATA_W-1:0]  ram [WORDS] = '{default: '0};

  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_hit_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [DATA_W-1:0]  ram_rdata;
  logic               lookup_hit;
  logic               accept;
  logic               mem_last;
  logic               line_we;
  logic [DATA_W-1:0]  line_data;

  assign idx       = lat_addr[INDEX_W-1:0];
  assign tag       = lat_addr[ADDR_W-1:INDEX_W];
  assign ram_rdata = ram[lat_addr];

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_hit   = rsp_hit_q;

  // Next-state logic plus the strobes that commit a memory access on its final cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    mem_last   = 1'b0;
    line_we    = 1'b0;
    line_data  = ram_rdata;
    lookup_hit = valid_q[idx] && (tag_arr[idx] == tag);

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!lat_we && lookup_hit) begin
          state_d = RESP;
        end else begin
          state_d = MEM;
          cnt_d   = CNT_W'(RAM_LAT - 1);
        end
      end
      MEM: begin
        if (cnt_q == '0) begin
          mem_last = 1'b1;
          state_d  = RESP;
          // Reads always fill; writes update a hit line, or allocate when enabled
          line_we  = !lat_we || rsp_hit_q || WriteAlloc;
          line_data = lat_we ? lat_wdata : ram_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, request latch, valid bits and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      valid_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end
      if (state_q == LOOKUP) begin
        rsp_hit_q <= lookup_hit;
        if (!lat_we && lookup_hit) begin
          rsp_rdata_q <= data_arr[idx];
        end
      end
      if (mem_last) begin
        rsp_rdata_q <= lat_we ? lat_wdata : ram_rdata;
      end
      if (line_we) begin
        valid_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage; only written on the final cycle of a memory access
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= line_data;
    end
  end

  // Write-through into the backing RAM on the final memory cycle of a write
  always_ff @(posedge clk) begin
    if (mem_last && lat_we) begin
      ram[lat_addr] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_dm_cache_wt.sv
// Self-checking bench for dm_cache_wt. Keeps a behavioural model in which the
// cache is just "which word address each line currently holds" and the
// returned data is always the current RAM word (write-through keeps them equal).
module tb_dm_cache_wt;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int INDEX_W = 4;
  localparam int RAM_LAT = 2;
  localparam int LINES   = 2 ** INDEX_W;
  localparam int WORDS   = 2 ** ADDR_W;

`ifdef WRITE_ALLOCATE_EN
  localparam bit WriteAlloc = 1'b1;
`else
  localparam bit WriteAlloc = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [DATA_W-1:0] m_ram [WORDS];
  int                line_addr [LINES];

  dm_cache_wt_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dm_cache_wt #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .INDEX_W(INDEX_W),
    .RAM_LAT(RAM_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) line_addr[i] = -1;
  endtask

  task automatic model_access(input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wdata,
                              output logic [DATA_W-1:0] er, output logic eh,
                              output int ec);
    int i;
    i  = int'(addr) % LINES;
    eh = (line_addr[i] == int'(addr));
    if (!we) begin
      er = m_ram[addr];
      ec = eh ? 2 : RAM_LAT + 2;
      if (!eh) line_addr[i] = int'(addr);
    end else begin
      m_ram[addr] = wdata;
      er = wdata;
      ec = RAM_LAT + 2;
      if (WriteAlloc) line_addr[i] = int'(addr);
    end
  endtask

  // One bus transaction; cyc is the cycle number of the response (accept = cycle 0), -1 on timeout
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata,
                        output logic [DATA_W-1:0] rdata, output logic hit,
                        output int cyc, output logic held);
    int n;
    rdata = '0; hit = 1'b0; cyc = -1; held = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) return;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.rsp_valid) return;
    cyc   = n + 1;
    rdata = bus.rsp_rdata;
    hit   = bus.rsp_hit;
    @(posedge clk); #1;
    held = !bus.rsp_valid && (bus.rsp_rdata === rdata) && (bus.rsp_hit === hit);
  endtask

  task automatic transact(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata,
                          output logic [DATA_W-1:0] r, output logic h,
                          output int c, output logic held,
                          output logic [DATA_W-1:0] er, output logic eh,
                          output int ec);
    model_access(we, addr, wdata, er, eh, ec);
    do_req(we, addr, wdata, r, h, c, held);
  endtask

  task automatic preload();
    logic [DATA_W-1:0] r, er;
    logic h, eh, held;
    int c, ec;
    for (int a = 0; a < 64; a++) begin
      transact(1'b1, ADDR_W'(a), DATA_W'(32'hA5A5_0000 | a), r, h, c, held, er, eh, ec);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL reset_ready: got %b want 1", bus.req_ready);
    end
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid);
    end
    tests_run++;
    if (bus.rsp_rdata !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_rdata: got %h want 0", bus.rsp_rdata);
    end
    tests_run++;
    if (bus.rsp_hit !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_hit: got %b want 0", bus.rsp_hit);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss_hit();
    logic [DATA_W-1:0] r, er;
    logic h, eh, held;
    int c, ec;
    transact(1'b0, 12'h005, '0, r, h, c, held, er, eh, ec);
    tests_run++;
    if (c !== 4 || r !== 32'hA5A5_0005 || h !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_miss: got cyc=%0d data=%h hit=%b want cyc=4 data=a5a50005 hit=0", c, r, h);
    end
    tests_run++;
    if (held !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL read_miss_pulse: got held=%b want 1", held);
    end
    transact(1'b0, 12'h005, '0, r, h, c, held, er, eh, ec);
    tests_run++;
    if (c !== 2 || r !== 32'hA5A5_0005 || h !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL read_hit: got cyc=%0d data=%h hit=%b want cyc=2 data=a5a50005 hit=1", c, r, h);
    end
  endtask

  task automatic test_write_hit();
    logic [DATA_W-1:0] r, er;
    logic h, eh, held;
    int c, ec;
    transact(1'b1, 12'h005, 32'h0000_1234, r, h, c, held, er, eh, ec);
    tests_run++;
    if (c !== 4 || r !== 32'h0000_1234 || h !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL write_hit: got cyc=%0d data=%h hit=%b want cyc=4 data=00001234 hit=1", c, r, h);
    end
    transact(1'b0, 12'h005, '0, r, h, c, held, er, eh, ec);
    tests_run++;
    if (c !== 2 || r !== 32'h0000_1234 || h !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL write_hit_readback: got cyc=%0d data=%h hit=%b want cyc=2 data=00001234 hit=1", c, r, h);
    end
  endtask

  task automatic test_conflict();
    logic [DATA_W-1:0] r, er;
    logic h, eh, held;
    int c, ec;
    transact(1'b0, 12'h005, '0, r, h, c, held, er, eh, ec);
    transact(1'b0, 12'h015, '0, r, h, c, held, er, eh, ec);
    tests_run++;
    if (c !== 4 || r !== 32'hA5A5_0015 || h !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL conflict_fill: got cyc=%0d data=%h hit=%b want cyc=4 data=a5a50015 hit=0", c, r, h);
    end
    // The evicted word must come back from RAM with the earlier write-through value
    transact(1'b0, 12'h005, '0, r, h, c, held, er, eh, ec);
    tests_run++;
    if (c !== 4 || r !== 32'h0000_1234 || h !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL conflict_evicted: got cyc=%0d data=%h hit=%b want cyc=4 data=00001234 hit=0", c, r, h);
    end
  endtask

  task automatic test_write_miss();
    logic [DATA_W-1:0] r, er;
    logic h, eh, held;
    int c, ec, want_c;
    logic want_h;
    want_h = WriteAlloc;
    want_c = WriteAlloc ? 2 : RAM_LAT + 2;
    transact(1'b1, 12'h020, 32'hDEAD_BEEF, r, h, c, held, er, eh, ec);
    tests_run++;
    if (c !== 4 || r !== 32'hDEAD_BEEF || h !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_miss: got cyc=%0d data=%h hit=%b want cyc=4 data=deadbeef hit=0", c, r, h);
    end
    transact(1'b0, 12'h020, '0, r, h, c, held, er, eh, ec);
    tests_run++;
    if (c !== want_c || r !== 32'hDEAD_BEEF || h !== want_h) begin
      tests_failed++;
      $display("[TB] FAIL write_miss_readback: got cyc=%0d data=%h hit=%b want cyc=%0d data=deadbeef hit=%b",
               c, r, h, want_c, want_h);
    end
  endtask

  task automatic test_reset_abort();
    logic [DATA_W-1:0] r, er;
    logic h, eh, held;
    int c, ec, seen;
    transact(1'b0, 12'h007, '0, r, h, c, held, er, eh, ec);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 12'h030;
    bus.req_wdata = 32'h1111_1111;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++; $display("[TB] FAIL abort_no_response: got %0d pulses want 0", seen);
    end
    transact(1'b0, 12'h030, '0, r, h, c, held, er, eh, ec);
    tests_run++;
    if (r !== 32'hA5A5_0030 || h !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_ram_unchanged: got data=%h hit=%b want data=a5a50030 hit=0", r, h);
    end
    transact(1'b0, 12'h007, '0, r, h, c, held, er, eh, ec);
    tests_run++;
    if (r !== 32'hA5A5_0007 || h !== 1'b0 || c !== 4) begin
      tests_failed++;
      $display("[TB] FAIL abort_cache_cleared: got cyc=%0d data=%h hit=%b want cyc=4 data=a5a50007 hit=0", c, r, h);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_d [$];
    logic              exp_h [$];
    logic [DATA_W-1:0] er, dd;
    logic              eh, dh;
    int ec, accepts, resps, pending, busy_bad, spurious;
    accepts = 0; resps = 0; pending = 0; busy_bad = 0; spurious = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (bus.rsp_valid) begin
        resps++;
        if (exp_d.size() == 0) begin
          spurious++;
        end else begin
          dd = exp_d.pop_front();
          dh = exp_h.pop_front();
          tests_run++;
          if (bus.rsp_rdata !== dd || bus.rsp_hit !== dh) begin
            tests_failed++;
            $display("[TB] FAIL b2b_response: got data=%h hit=%b want data=%h hit=%b",
                     bus.rsp_rdata, bus.rsp_hit, dd, dh);
          end
          pending = 0;
        end
      end
      if (bus.req_ready && pending != 0) busy_bad++;
      if (cyc < 40) begin
        bus.req_valid = 1'b1;
        bus.req_we    = ($urandom_range(0, 3) == 0);
        bus.req_addr  = ADDR_W'($urandom_range(0, 63));
        bus.req_wdata = $urandom;
        if (bus.req_ready) begin
          model_access(bus.req_we, bus.req_addr, bus.req_wdata, er, eh, ec);
          exp_d.push_back(er);
          exp_h.push_back(eh);
          accepts++;
          pending = 1;
        end
      end else begin
        bus.req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (accepts !== resps || accepts < 5 || spurious != 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_counts: got accepts=%0d responses=%0d spurious=%0d want equal, >=5, 0",
               accepts, resps, spurious);
    end
    tests_run++;
    if (busy_bad != 0) begin
      tests_failed++; $display("[TB] FAIL b2b_ready_busy: got %0d busy-ready cycles want 0", busy_bad);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] r, er;
    logic h, eh, held, we;
    logic [ADDR_W-1:0] a;
    int c, ec;
    for (int i = 0; i < 150; i++) begin
      we = ($urandom_range(0, 9) < 3);
      a  = ADDR_W'($urandom_range(0, 63));
      transact(we, a, $urandom, r, h, c, held, er, eh, ec);
      tests_run++;
      if (r !== er || h !== eh || c !== ec || held !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d: addr=%h we=%b got data=%h hit=%b cyc=%0d held=%b want data=%h hit=%b cyc=%0d held=1",
                 i, a, we, r, h, c, held, er, eh, ec);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < WORDS; i++) m_ram[i] = '0;
    model_reset();
    #12;
    rst = 1'b0;
    @(posedge clk); #1;
    preload();
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_conflict();
    test_write_miss();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
